// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_lock;
        logic if_id_lock;
        logic if_id_flush;
        logic id_ex_lock;
        logic id_ex_flush;
        logic ex_mem_lock;
        logic ex_mem_flush;
        logic mdu_done;
    } hz_ctrl_t;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic                  ex_mem_read,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  uses_rs1,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic                  uses_rs2,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return ex_mem_read && (ex_rd != REG_X0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves dmem wait, redirect, MDU occupancy and
// load-use by fixed priority and counts stalled cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_redirect_i,
    input  logic                  ex_mdu_start_i,
    input  logic                  dmem_wait_i,
    output logic                  pc_lock_o,
    output logic                  if_id_lock_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_lock_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_lock_o,
    output logic                  ex_mem_flush_o,
    output logic                  mdu_done_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int CNT_BITS = $clog2(MDU_LAT);
    // Start cycle plus the final done cycle are not counted by cnt.
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MDU_LAT - 2);

    hz_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    hz_ctrl_t            ctrl_raw, ctrl;
    logic                load_use;

    assign load_use = load_use_hit(ex_mem_read_i, ex_rd_i, id_uses_rs1_i, id_rs1_i,
                                   id_uses_rs2_i, id_rs2_i);

    always_comb begin
        ctrl_raw = '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (dmem_wait_i) begin
            ctrl_raw.pc_lock     = 1'b1;
            ctrl_raw.if_id_lock  = 1'b1;
            ctrl_raw.id_ex_lock  = 1'b1;
            ctrl_raw.ex_mem_lock = 1'b1;
        end else if (state_q == RUN) begin
            if (ex_redirect_i) begin
                ctrl_raw.if_id_flush = 1'b1;
                ctrl_raw.id_ex_flush = 1'b1;
            end else if (ex_mdu_start_i) begin
                ctrl_raw.pc_lock      = 1'b1;
                ctrl_raw.if_id_lock   = 1'b1;
                ctrl_raw.id_ex_lock   = 1'b1;
                ctrl_raw.ex_mem_flush = 1'b1;
                cnt_d                 = CNT_LOAD;
                state_d               = MDU_WAIT;
            end else if (load_use) begin
                ctrl_raw.pc_lock     = 1'b1;
                ctrl_raw.if_id_lock  = 1'b1;
                ctrl_raw.id_ex_flush = 1'b1;
            end
        end else if (cnt_q != '0) begin
            ctrl_raw.pc_lock      = 1'b1;
            ctrl_raw.if_id_lock   = 1'b1;
            ctrl_raw.id_ex_lock   = 1'b1;
            ctrl_raw.ex_mem_flush = 1'b1;
            cnt_d                 = cnt_q - CNT_BITS'(1);
        end else begin
            // Final MDU cycle: the op leaves EX, start is still high for it.
            ctrl_raw.mdu_done = 1'b1;
            state_d           = RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ctrl = rst_i ? hz_ctrl_t'('0) : ctrl_raw;

    assign pc_lock_o      = ctrl.pc_lock;
    assign if_id_lock_o   = ctrl.if_id_lock;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_lock_o   = ctrl.id_ex_lock;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_lock_o  = ctrl.ex_mem_lock;
    assign ex_mem_flush_o = ctrl.ex_mem_flush;
    assign mdu_done_o     = ctrl.mdu_done;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ctrl.pc_lock),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: MDU_LAT=4 main instance, MDU_LAT=2 side instance.
module tb_hazard_ctrl;

    // {pc_lock, if_id_lock, if_id_flush, id_ex_lock, id_ex_flush, ex_mem_lock, ex_mem_flush, mdu_done}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] FREEZE = 8'b1101_0100;
    localparam logic [7:0] REDIR  = 8'b0010_1000;
    localparam logic [7:0] MDU    = 8'b1101_0010;
    localparam logic [7:0] LU     = 8'b1100_1000;
    localparam logic [7:0] DONE   = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic       mdu_start, mdu_start_b, dmem_wait;

    logic pc_lock_a, if_id_lock_a, if_id_flush_a, id_ex_lock_a, id_ex_flush_a;
    logic ex_mem_lock_a, ex_mem_flush_a, mdu_done_a;
    logic [3:0] cnt_a;
    logic pc_lock_b, if_id_lock_b, if_id_flush_b, id_ex_lock_b, id_ex_flush_b;
    logic ex_mem_lock_b, ex_mem_flush_b, mdu_done_b;
    logic [3:0] cnt_b;
    logic [7:0] ctrl_a, ctrl_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctrl_a = {pc_lock_a, if_id_lock_a, if_id_flush_a, id_ex_lock_a, id_ex_flush_a,
                     ex_mem_lock_a, ex_mem_flush_a, mdu_done_a};
    assign ctrl_b = {pc_lock_b, if_id_lock_b, if_id_flush_b, id_ex_lock_b, id_ex_flush_b,
                     ex_mem_lock_b, ex_mem_flush_b, mdu_done_b};

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .ex_redirect_i(ex_redirect), .ex_mdu_start_i(mdu_start), .dmem_wait_i(dmem_wait),
        .pc_lock_o(pc_lock_a), .if_id_lock_o(if_id_lock_a), .if_id_flush_o(if_id_flush_a),
        .id_ex_lock_o(id_ex_lock_a), .id_ex_flush_o(id_ex_flush_a),
        .ex_mem_lock_o(ex_mem_lock_a), .ex_mem_flush_o(ex_mem_flush_a),
        .mdu_done_o(mdu_done_a), .stall_cnt_o(cnt_a)
    );

    hazard_ctrl #(.MDU_LAT(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
        .ex_redirect_i(ex_redirect), .ex_mdu_start_i(mdu_start_b), .dmem_wait_i(dmem_wait),
        .pc_lock_o(pc_lock_b), .if_id_lock_o(if_id_lock_b), .if_id_flush_o(if_id_flush_b),
        .id_ex_lock_o(id_ex_lock_b), .id_ex_flush_o(id_ex_flush_b),
        .ex_mem_lock_o(ex_mem_lock_b), .ex_mem_flush_o(ex_mem_flush_b),
        .mdu_done_o(mdu_done_b), .stall_cnt_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mdu_start = 1'b0; mdu_start_b = 1'b0; dmem_wait = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
    endtask

    logic [7:0] seq_w [6];
    logic [5:0] wait_w;
    logic [7:0] seq_d [5];
    logic [4:0] wait_d;

    initial begin
        rst = 1'b1;
        idle();
        // Outputs stay low in reset even with hazards on the inputs.
        #2; dmem_wait = 1'b1; set_lu(5'd5); #1;
        check("rst_ctrl_a", {24'd0, ctrl_a}, {24'd0, NONE});
        check("rst_ctrl_b", {24'd0, ctrl_b}, {24'd0, NONE});
        check("rst_cnt_a", {28'd0, cnt_a}, 32'd0);

        @(negedge clk); idle(); rst = 1'b0; #1;
        check("idle", {24'd0, ctrl_a}, {24'd0, NONE});

        // Load-use on rs2
        @(negedge clk); idle(); set_lu(5'd5); #1;
        check("lu_rs2", {24'd0, ctrl_a}, {24'd0, LU});
        check("lu_cnt0", {28'd0, cnt_a}, 32'd0);
        @(negedge clk); idle(); #1;
        check("lu_one_cycle", {24'd0, ctrl_a}, {24'd0, NONE});
        check("lu_cnt1", {28'd0, cnt_a}, 32'd1);

        // Load to x0 never stalls
        @(negedge clk); idle(); set_lu(5'd0); #1;
        check("lu_x0", {24'd0, ctrl_a}, {24'd0, NONE});

        // rs1 match only counts when rs1 is used
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; #1;
        check("lu_rs1_unused", {24'd0, ctrl_a}, {24'd0, NONE});
        @(negedge clk); id_uses_rs1 = 1'b1; #1;
        check("lu_rs1", {24'd0, ctrl_a}, {24'd0, LU});
        @(negedge clk); ex_mem_read = 1'b0; #1;
        check("no_load", {24'd0, ctrl_a}, {24'd0, NONE});
        check("lu_cnt2", {28'd0, cnt_a}, 32'd2);

        // Redirect wins over load-use and MDU start
        @(negedge clk); idle(); ex_redirect = 1'b1; set_lu(5'd3); #1;
        check("redir_lu", {24'd0, ctrl_a}, {24'd0, REDIR});
        @(negedge clk); idle(); ex_redirect = 1'b1; mdu_start = 1'b1; #1;
        check("redir_mdu", {24'd0, ctrl_a}, {24'd0, REDIR});
        @(negedge clk); idle(); #1;
        check("redir_stays_run", {24'd0, ctrl_a}, {24'd0, NONE});
        check("redir_cnt", {28'd0, cnt_a}, 32'd2);

        // MDU op, redirect and load-use ignored while it occupies EX
        @(negedge clk); idle(); mdu_start = 1'b1; #1;
        check("mdu_c0", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); ex_redirect = 1'b1; #1;
        check("mdu_c1", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); ex_redirect = 1'b0; set_lu(5'd9); #1;
        check("mdu_c2", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); #1;
        check("mdu_c3_done", {24'd0, ctrl_a}, {24'd0, DONE});
        @(negedge clk); idle(); #1;
        check("mdu_after", {24'd0, ctrl_a}, {24'd0, NONE});
        check("mdu_cnt", {28'd0, cnt_a}, 32'd5);

        // Memory wait of 2 cycles starting in cycle 1
        seq_w  = '{MDU, FREEZE, FREEZE, MDU, MDU, DONE};
        wait_w = 6'b000110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); idle(); mdu_start = 1'b1; dmem_wait = wait_w[i]; #1;
            check($sformatf("mwait_c%0d", i), {24'd0, ctrl_a}, {24'd0, seq_w[i]});
        end
        @(negedge clk); idle(); #1;
        check("mwait_cnt", {28'd0, cnt_a}, 32'd10);

        // Memory wait in the final MDU cycle suppresses done
        seq_d  = '{MDU, MDU, MDU, FREEZE, DONE};
        wait_d = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idle(); mdu_start = 1'b1; dmem_wait = wait_d[i]; #1;
            check($sformatf("dwait_c%0d", i), {24'd0, ctrl_a}, {24'd0, seq_d[i]});
        end
        @(negedge clk); idle(); #1;
        check("dwait_idle", {24'd0, ctrl_a}, {24'd0, NONE});
        check("dwait_cnt", {28'd0, cnt_a}, 32'd14);

        // Two more stalls take the 4-bit counter through 15 and back to 0
        @(negedge clk); idle(); set_lu(5'd4); #1;
        check("wrap_lu0", {24'd0, ctrl_a}, {24'd0, LU});
        @(negedge clk); #1;
        check("wrap_cnt15", {28'd0, cnt_a}, 32'd15);
        @(negedge clk); idle(); #1;
        check("wrap_cnt0", {28'd0, cnt_a}, 32'd0);

        // Minimum latency instance: lock one cycle, done the next
        @(negedge clk); idle(); mdu_start_b = 1'b1; #1;
        check("mdu2_c0", {24'd0, ctrl_b}, {24'd0, MDU});
        @(negedge clk); #1;
        check("mdu2_c1_done", {24'd0, ctrl_b}, {24'd0, DONE});
        @(negedge clk); idle(); #1;
        check("mdu2_after", {24'd0, ctrl_b}, {24'd0, NONE});

        // Asynchronous reset while in MDU_WAIT
        @(negedge clk); idle(); mdu_start = 1'b1; #1;
        check("rmdu_c0", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); #1;
        check("rmdu_c1", {24'd0, ctrl_a}, {24'd0, MDU});
        #2; rst = 1'b1; #1;
        check("rmdu_async_ctrl", {24'd0, ctrl_a}, {24'd0, NONE});
        check("rmdu_async_cnt", {28'd0, cnt_a}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("post_rst_c0", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); #1;
        check("post_rst_c1", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); #1;
        check("post_rst_c2", {24'd0, ctrl_a}, {24'd0, MDU});
        @(negedge clk); #1;
        check("post_rst_c3_done", {24'd0, ctrl_a}, {24'd0, DONE});
        @(negedge clk); idle(); #1;
        check("post_rst_cnt", {28'd0, cnt_a}, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the lock/flush controls of the pipeline latches. It is the producer side of the IF/ID latch's `if_id_lock`/`if_id_flush` interface, and also drives the matching controls for the PC, ID/EX and EX/MEM registers. It resolves four hazards by fixed priority: data-memory wait, EX-stage redirect, multi-cycle MDU occupancy and load-use. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- `MDU_LAT`, default 4: total cycles an MDU op occupies EX. Legal values are 2 and above.
- `CNT_W`, default 32: width of the stall counter.

Ports:
- `clk_i` in 1: clock, rising-edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `id_rs1_i`, `id_rs2_i` in 5: source registers of the instruction in ID.
- `id_uses_rs1_i`, `id_uses_rs2_i` in 1: the instruction in ID reads rs1 / rs2.
- `ex_rd_i` in 5: destination register of the instruction in EX.
- `ex_mem_read_i` in 1: the instruction in EX is a load.
- `ex_redirect_i` in 1: a taken branch or jump is in EX; the PC loads the target this cycle.
- `ex_mdu_start_i` in 1: an MDU op is in EX. Held high for as long as it stays in EX.
- `dmem_wait_i` in 1: the MEM-stage data memory is not ready.
- `pc_lock_o` out 1: hold the PC.
- `if_id_lock_o`, `if_id_flush_o` out 1: controls for the IF/ID latch.
- `id_ex_lock_o`, `id_ex_flush_o` out 1: controls for the ID/EX latch. Flush inserts a bubble.
- `ex_mem_lock_o`, `ex_mem_flush_o` out 1: controls for the EX/MEM latch.
- `mdu_done_o` out 1: one-cycle pulse in the final MDU cycle.
- `stall_cnt_o` out CNT_W: count of cycles with `pc_lock_o`=1.

## Operation
- FSM states:
  - RUN
  - MDU_WAIT
- Registers:
  - `state`
  - `cnt` (down-counter, width clog2(MDU_LAT))
  - `stall_cnt`
- Outputs are combinational from `state`, `cnt` and the inputs. Every output not named in a case below is 0.
- Priority in each cycle, highest first:
  1. `dmem_wait_i`: freeze.
     - `pc_lock_o`, `if_id_lock_o`, `id_ex_lock_o` and `ex_mem_lock_o` are 1. No flushes.
     - `state` and `cnt` hold.
     - `mdu_done_o` is 0, even if `cnt`==0.
  2. RUN and `ex_redirect_i`:
     - `if_id_flush_o`=1 and `id_ex_flush_o`=1.
     - PC not locked.
     - Any simultaneous load-use or MDU start is ignored; state stays RUN.
  3. RUN and `ex_mdu_start_i`:
     - `pc_lock_o`, `if_id_lock_o` and `id_ex_lock_o` are 1; `ex_mem_flush_o`=1.
     - Load `cnt` with MDU_LAT-2; next state is MDU_WAIT.
  4. RUN and load-use. Load-use means `ex_mem_read_i` and `ex_rd_i`≠0 and ((`id_uses_rs1_i` and `id_rs1_i`==`ex_rd_i`) or (`id_uses_rs2_i` and `id_rs2_i`==`ex_rd_i`)).
     - `pc_lock_o`=1, `if_id_lock_o`=1, `id_ex_flush_o`=1.
     - Single cycle, no state change. Forwarding covers the following cycle.
  5. MDU_WAIT with `cnt`≠0:
     - Same outputs as case 3; `cnt` decrements.
     - `ex_mdu_start_i`, `ex_redirect_i` and load-use are ignored.
  6. MDU_WAIT with `cnt`==0:
     - `mdu_done_o`=1, all locks 0; next state is RUN.
     - `ex_mdu_start_i` is ignored (it is still high for the op that is leaving).
- `stall_cnt` increments on each clock edge where `pc_lock_o`=1. It wraps from 2^CNT_W-1 to 0.
- Lock and flush are never both asserted on the same latch.

## Timing
- Reset (`rst_i`=1, asynchronous):
  - `state`=RUN, `cnt`=0, `stall_cnt`=0.
  - All outputs are forced to 0 while `rst_i` is high, independent of inputs.
- Zero-cycle latency: each control is valid in the same cycle as its cause and is sampled by the latches at the next rising edge.
- MDU occupancy:
  - The op stays in EX for exactly MDU_LAT cycles when no `dmem_wait_i` occurs.
  - Upstream locks are asserted for MDU_LAT-1 cycles.
  - `mdu_done_o` is high in cycle MDU_LAT-1, counting from the start cycle as cycle 0.
  - Each `dmem_wait_i` cycle extends the sequence by one cycle.
- Load-use costs exactly one bubble.
- Redirect costs two flushed slots: IF/ID and ID/EX.
- Reset mid-MDU: the FSM returns to RUN immediately. The first RUN cycle after release evaluates inputs normally.

## Structure
- `hazard_pkg`:
  - state enum (RUN, MDU_WAIT)
  - `REG_ADDR_W`=5
  - x0 index constant
- One natural sub-module, `perf_counter` (CNT_W, enable input, wrap), for `stall_cnt`. Later perf counters will reuse it.
- The rest is a single always_ff for `state`/`cnt` plus one combinational priority block.

## Test plan
- Load-use:
  - Stimulus: `ex_mem_read_i`=1, `ex_rd_i`=5, `id_rs2_i`=5, `id_uses_rs2_i`=1.
  - Response: in that cycle only, `pc_lock_o`=1, `if_id_lock_o`=1, `id_ex_flush_o`=1; `stall_cnt_o` goes 0→1.
  - Repeat with `ex_rd_i`=0: no stall.
- Redirect:
  - Stimulus: `ex_redirect_i`=1 together with a load-use match.
  - Response: `if_id_flush_o`=1, `id_ex_flush_o`=1, `pc_lock_o`=0.
- MDU, MDU_LAT=4:
  - Stimulus: `ex_mdu_start_i` held high for 4 cycles.
  - Response: locks high in cycles 0–2, `mdu_done_o`=1 in cycle 3, `stall_cnt_o`=3.
- Memory wait mid-MDU:
  - Stimulus: `dmem_wait_i`=1 for 2 cycles during cycle 1.
  - Response: all four locks high; `mdu_done_o` arrives 2 cycles later, in cycle 5.
- Reset and counter wrap:
  - Stimulus: assert `rst_i` in MDU_WAIT.
  - Response: outputs drop to 0 asynchronously and the FSM is in RUN after release.
  - With CNT_W=4, 16 stall cycles wrap `stall_cnt_o` to 0.
